ddr2_arbiter: RTL

- Shares the single DDR2 manager command port between two requesters: display line-fetch reads from frac_disp (req_rd_ddr / req_ddr_addr_row) and fractal-unit pixel writes.
- Display reads have strict priority; a frac write is never preempted once issued.
- Sits in the DDR2_MGR slot of the PicoBlaze port bus (block-select bit 1), which exposes control, status and grant counters.

---
 rtl/ddr2_arbiter_if.sv | 38 +++
 rtl/ddr2_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_arbiter_if.sv
// Command port between the arbiter and the DDR2 manager.
// Latency: n/a (signal bundle only).
// Backpressure: cmd_valid is held with stable payload until cmd_ready; cmd_done closes the command.
//
// Signals:
//   cmd_valid  arbiter -> manager  command valid
//   cmd_ready  manager -> arbiter  command accepted when cmd_valid & cmd_ready
//   cmd_rd     arbiter -> manager  1 = display read, 0 = frac write
//   cmd_row    arbiter -> manager  13-bit row
//   cmd_col    arbiter -> manager  10-bit column (0 for display reads)
//   cmd_done   manager -> arbiter  pulse: outstanding command finished
interface ddr2_arbiter_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rd;
    logic [12:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        cmd_done;

    // The arbiter side drives the command, the manager side answers it.
    modport master (
        output cmd_valid,
        output cmd_rd,
        output cmd_row,
        output cmd_col,
        input  cmd_ready,
        input  cmd_done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_rd,
        input  cmd_row,
        input  cmd_col,
        output cmd_ready,
        output cmd_done
    );
endinterface

// File: rtl/ddr2_arbiter.sv
// Shares the DDR2 manager command port between display line-fetch reads (strict priority) and frac pixel writes.
// Latency: a request seen in IDLE is presented on cmd the next cycle; done/ack pulse one cycle after cmd_done.
// Backpressure: cmd_valid and its payload hold until cmd_ready; one command outstanding at a time, never preempted.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   pi_*                PicoBlaze port bus (regs: 0 CTRL, 1 STATUS, 2 DISP_CNT, 3 FRAC_CNT)
//   req_rd_ddr/_row     display fetch request pulse and its row
//   disp_fill_done      pulse: display read completed
//   frac_wr_req/_row/_col, frac_wr_ack   frac write request (level) and completion pulse
//   cmd                 command port to the DDR2 manager (master side)
module ddr2_arbiter #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int TO_W        = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pi_blk_sel,
    input  logic [3:0]    pi_addr,
    input  logic          pi_wr_en,
    input  logic          pi_rd_en,
    input  logic [7:0]    pi_wr_data,
    output logic [7:0]    pi_rd_data,
    input  logic          req_rd_ddr,
    input  logic [12:0]   req_ddr_addr_row,
    output logic          disp_fill_done,
    input  logic          frac_wr_req,
    input  logic [12:0]   frac_wr_row,
    input  logic [9:0]    frac_wr_col,
    output logic          frac_wr_ack,
    ddr2_arbiter_if.master cmd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_RD,
        S_WAIT_RD,
        S_ISSUE_WR,
        S_WAIT_WR
    } state_t;

    state_t      state_q, state_d;

    logic        disp_pend_q;
    logic [12:0] disp_row_q;
    logic        frac_en_q;
    logic        overrun_q;
    logic        timeout_q;
    logic [7:0]  disp_cnt_q;
    logic [7:0]  frac_cnt_q;
    logic [TO_W-1:0] to_cnt_q;

    logic        cmd_rd_q;
    logic [12:0] cmd_row_q;
    logic [9:0]  cmd_col_q;

    // FSM decode strobes
    logic        load_rd;
    logic        load_wr;
    logic        rd_done;
    logic        wr_done;
    logic        to_hit;

    logic        rd_elig;
    logic        wr_elig;
    logic [12:0] rd_row_src;
    logic        rd_hs;
    logic        in_wait;
    logic        to_expire;
    logic        ctrl_wr;
    logic        flag_clr;
    logic        overrun_set;
    logic        busy;
    logic        owner;
    logic        unused_bits;

    // A request arriving in IDLE is issued directly, so it bypasses the pending register.
    assign rd_elig    = disp_pend_q | req_rd_ddr;
    assign wr_elig    = frac_wr_req & frac_en_q;
    assign rd_row_src = req_rd_ddr ? req_ddr_addr_row : disp_row_q;

    assign rd_hs      = (state_q == S_ISSUE_RD) & cmd.cmd_ready;
    assign in_wait    = (state_q == S_WAIT_RD) | (state_q == S_WAIT_WR);
    assign to_expire  = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    assign busy       = (state_q != S_IDLE);
    assign owner      = (state_q == S_ISSUE_WR) | (state_q == S_WAIT_WR);

    assign ctrl_wr    = pi_blk_sel & pi_wr_en & (pi_addr == 4'd0);
    assign flag_clr   = ctrl_wr & pi_wr_data[7];
    // A request landing on the issue handshake of the previous one is a fresh request, not an overrun.
    assign overrun_set = req_rd_ddr & disp_pend_q & ~rd_hs;

    assign unused_bits = ^pi_wr_data[6:1];

    assign cmd.cmd_valid = (state_q == S_ISSUE_RD) | (state_q == S_ISSUE_WR);
    assign cmd.cmd_rd    = cmd_rd_q;
    assign cmd.cmd_row   = cmd_row_q;
    assign cmd.cmd_col   = cmd_col_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load_rd = 1'b0;
        load_wr = 1'b0;
        rd_done = 1'b0;
        wr_done = 1'b0;
        to_hit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_elig) begin
                    state_d = S_ISSUE_RD;
                    load_rd = 1'b1;
                end else if (wr_elig) begin
                    state_d = S_ISSUE_WR;
                    load_wr = 1'b1;
                end
            end
            S_ISSUE_RD: begin
                if (cmd.cmd_ready) begin
                    state_d = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (cmd.cmd_done) begin
                    state_d = S_IDLE;
                    rd_done = 1'b1;
                end else if (to_expire) begin
                    state_d = S_IDLE;
                    to_hit  = 1'b1;
                end
            end
            S_ISSUE_WR: begin
                if (cmd.cmd_ready) begin
                    state_d = S_WAIT_WR;
                end
            end
            S_WAIT_WR: begin
                if (cmd.cmd_done) begin
                    state_d = S_IDLE;
                    wr_done = 1'b1;
                end else if (to_expire) begin
                    state_d = S_IDLE;
                    to_hit  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- Command payload, latched on state entry ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_rd_q  <= 1'b0;
            cmd_row_q <= '0;
            cmd_col_q <= '0;
        end else if (load_rd) begin
            cmd_rd_q  <= 1'b1;
            cmd_row_q <= rd_row_src;
            cmd_col_q <= '0;
        end else if (load_wr) begin
            cmd_rd_q  <= 1'b0;
            cmd_row_q <= frac_wr_row;
            cmd_col_q <= frac_wr_col;
        end
    end

    // ---------------- Display request capture ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_pend_q <= 1'b0;
            disp_row_q  <= '0;
        end else if (req_rd_ddr) begin
            disp_pend_q <= 1'b1;
            disp_row_q  <= req_ddr_addr_row;
        end else if (rd_hs) begin
            disp_pend_q <= 1'b0;
        end
    end

    // ---------------- Timeout counter: runs only while waiting ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (in_wait) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end

    // ---------------- Completion pulses and grant counters ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_fill_done <= 1'b0;
            frac_wr_ack    <= 1'b0;
            disp_cnt_q     <= '0;
            frac_cnt_q     <= '0;
        end else begin
            disp_fill_done <= rd_done;
            frac_wr_ack    <= wr_done;
            if (rd_done) begin
                disp_cnt_q <= disp_cnt_q + 8'd1;
            end
            if (wr_done) begin
                frac_cnt_q <= frac_cnt_q + 8'd1;
            end
        end
    end

    // ---------------- Control and sticky flags (set beats clear) ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frac_en_q <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                frac_en_q <= pi_wr_data[0];
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (flag_clr) begin
                overrun_q <= 1'b0;
            end
            if (to_hit) begin
                timeout_q <= 1'b1;
            end else if (flag_clr) begin
                timeout_q <= 1'b0;
            end
        end
    end

    // ---------------- Register read; zero when not selected so the bus can be OR-combined ----------------
    always_comb begin
        pi_rd_data = 8'h00;
        if (pi_blk_sel && pi_rd_en) begin
            case (pi_addr)
                4'd0:    pi_rd_data = {7'b0, frac_en_q};
                4'd1:    pi_rd_data = {2'b0, frac_wr_req, disp_pend_q, timeout_q, overrun_q, owner, busy};
                4'd2:    pi_rd_data = disp_cnt_q;
                4'd3:    pi_rd_data = frac_cnt_q;
                default: pi_rd_data = 8'h00;
            endcase
        end
    end

endmodule
